// File: rtl/csr_master.sv
// csr_master: host-side initiator for the individual CSR registers.
// Accepts one access at a time, pulses the addressed register's enable for a
// single cycle, captures the register's pre-update value and returns it.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a request; latch it and decode the address
// ISSUE   | csr_en pulse to the addressed register (one cycle)
// CAPTURE | sample the register's old-value output into the response
// RESP    | response held until rsp_ready
module csr_master #(
    parameter int          NumCsr   = 4,
    parameter logic [11:0] BaseAddr = 12'h300
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [11:0]            req_addr_i,
    input  logic [2:0]             req_op_i,
    input  logic [31:0]            req_wdata_i,
    input  logic [4:0]             req_imm_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic [NumCsr-1:0]      csr_en_o,
    output logic [2:0]             csr_op_o,
    output logic [31:0]            csr_in_o,
    output logic [4:0]             csr_rs1_o,
    input  logic [NumCsr*32-1:0]   csr_old_i
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StIssue   = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;
    localparam logic [1:0] StResp    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  imm_q, imm_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [11:0] idx_full;
    logic        req_bad;
    logic [31:0] old_sel;

    // Addresses below BaseAddr wrap to large indices and fall out of range.
    assign idx_full = req_addr_i - BaseAddr;
    // Op encodings 000 and 100 are not CSR operations.
    assign req_bad  = (idx_full >= 12'(NumCsr)) || (req_op_i[1:0] == 2'b00);

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign csr_op_o    = op_q;
    assign csr_in_o    = wdata_q;
    assign csr_rs1_o   = imm_q;

    // Select the addressed register's old-value output.
    always_comb begin
        old_sel = '0;
        for (int i = 0; i < NumCsr; i++) begin
            if (idx_q == 4'(i)) begin
                old_sel = csr_old_i[i*32 +: 32];
            end
        end
    end

    // One-hot enable, only while in ISSUE.
    always_comb begin
        csr_en_o = '0;
        if (state_q == StIssue) begin
            for (int i = 0; i < NumCsr; i++) begin
                csr_en_o[i] = (idx_q == 4'(i));
            end
        end
    end

    // Sequencing and request/response capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        imm_d   = imm_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    idx_d   = idx_full[3:0];
                    op_d    = req_op_i;
                    wdata_d = req_wdata_i;
                    imm_d   = req_imm_i;
                    if (req_bad) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                state_d = StCapture;
            end
            StCapture: begin
                rdata_d = old_sel;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            imm_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            imm_q   <= imm_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
